// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 32-bit barrel shifter (IDLE/EXEC/RESP).
// Optional sign-fill for arithmetic right shifts is enabled by defining SHIFT_ARBITER_SRA_EN.
module shift_arbiter (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0_VALID,
   output logic        REQ0_READY,
   input  logic [31:0] REQ0_D,
   input  logic [31:0] REQ0_S,
   input  logic        REQ0_LNR,
   input  logic        REQ0_SRA,
   input  logic        REQ1_VALID,
   output logic        REQ1_READY,
   input  logic [31:0] REQ1_D,
   input  logic [31:0] REQ1_S,
   input  logic        REQ1_LNR,
   input  logic        REQ1_SRA,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [31:0] RSP_Y,
   output logic        RSP_ID
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nx;
   logic        ptr;
   logic        grant_id;
   logic        any_valid;
   logic        accept;
   logic [31:0] op_d, op_s;
   logic        op_lnr, op_id;
   logic [31:0] shift_in, shift_val, shift_mid, shift_res;
   logic        big_shift;
`ifdef SHIFT_ARBITER_SRA_EN
   logic        op_sra;
   logic        fill;
`else
   logic        unused_sra;
   assign unused_sra = REQ0_SRA ^ REQ1_SRA;
`endif

   function automatic logic [31:0] bit_rev(input logic [31:0] x);
      logic [31:0] r;
      for (int unsigned i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction

   assign any_valid = REQ0_VALID | REQ1_VALID;
   assign grant_id  = (REQ0_VALID & REQ1_VALID) ? ptr : REQ1_VALID;
   assign accept    = (state == IDLE) & any_valid & ~RST;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = EXEC;
         EXEC:    state_nx = RESP;
         RESP:    if (RSP_READY) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      REQ0_READY = accept & ~grant_id;
      REQ1_READY = accept & grant_id;
      RSP_VALID  = (state == RESP);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr    <= 1'b0;
         op_d   <= '0;
         op_s   <= '0;
         op_lnr <= 1'b0;
         op_id  <= 1'b0;
`ifdef SHIFT_ARBITER_SRA_EN
         op_sra <= 1'b0;
`endif
      end else if (accept) begin
         ptr    <= ~grant_id;
         op_d   <= grant_id ? REQ1_D   : REQ0_D;
         op_s   <= grant_id ? REQ1_S   : REQ0_S;
         op_lnr <= grant_id ? REQ1_LNR : REQ0_LNR;
         op_id  <= grant_id;
`ifdef SHIFT_ARBITER_SRA_EN
         op_sra <= grant_id ? REQ1_SRA : REQ0_SRA;
`endif
      end
   end

   // Left shifts reuse the right-shift stages by bit-reversing operand and result.
   always_comb begin
      shift_in  = op_lnr ? bit_rev(op_d) : op_d;
      shift_val = shift_in;
      big_shift = |op_s[31:5];
`ifdef SHIFT_ARBITER_SRA_EN
      fill = op_sra & ~op_lnr & op_d[31];
`endif
      for (int unsigned i = 0; i < 5; i++) begin
         if (op_s[i]) begin
`ifdef SHIFT_ARBITER_SRA_EN
            shift_val = (shift_val >> (1 << i)) |
                        ({32{fill}} & ~(32'hFFFF_FFFF >> (1 << i)));
`else
            shift_val = shift_val >> (1 << i);
`endif
         end
      end
`ifdef SHIFT_ARBITER_SRA_EN
      shift_mid = big_shift ? {32{fill}} : shift_val;
`else
      shift_mid = big_shift ? '0 : shift_val;
`endif
      shift_res = op_lnr ? bit_rev(shift_mid) : shift_mid;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RSP_Y  <= '0;
         RSP_ID <= 1'b0;
      end else if (state == EXEC) begin
         RSP_Y  <= shift_res;
         RSP_ID <= op_id;
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed self-checking bench for shift_arbiter against a behavioural model.
module tb_shift_arbiter;

`ifdef SHIFT_ARBITER_SRA_EN
   localparam bit SRA_ON = 1'b1;
`else
   localparam bit SRA_ON = 1'b0;
`endif

   logic        CLK, RST;
   logic        REQ0_VALID, REQ0_READY, REQ0_LNR, REQ0_SRA;
   logic        REQ1_VALID, REQ1_READY, REQ1_LNR, REQ1_SRA;
   logic [31:0] REQ0_D, REQ0_S, REQ1_D, REQ1_S;
   logic        RSP_VALID, RSP_READY, RSP_ID;
   logic [31:0] RSP_Y;

   int   total = 0;
   int   bad   = 0;
   logic m_ptr = 1'b0;

   shift_arbiter dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_D(REQ0_D), .REQ0_S(REQ0_S),
      .REQ0_LNR(REQ0_LNR), .REQ0_SRA(REQ0_SRA),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_D(REQ1_D), .REQ1_S(REQ1_S),
      .REQ1_LNR(REQ1_LNR), .REQ1_SRA(REQ1_SRA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_Y(RSP_Y), .RSP_ID(RSP_ID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] s,
                                             input logic lnr, input logic sra);
      logic signed [31:0] sd;
      if (lnr) return d << s;
      if (sra && SRA_ON) begin
         sd = d;
         return sd >>> s;
      end
      return d >> s;
   endfunction

   task automatic reset_dut();
      RST = 1'b1;
      REQ0_VALID = 1'b1;
      REQ1_VALID = 1'b1;
      @(posedge CLK); #1;
      check("rst_rdy0",  {31'b0, REQ0_READY}, 32'd0);
      check("rst_rdy1",  {31'b0, REQ1_READY}, 32'd0);
      check("rst_valid", {31'b0, RSP_VALID},  32'd0);
      check("rst_y",     RSP_Y,               32'd0);
      check("rst_id",    {31'b0, RSP_ID},     32'd0);
      RST = 1'b0;
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b0;
      m_ptr = 1'b0;
      @(posedge CLK); #1;
   endtask

   // One accepted operation from IDLE through RESP; caller guarantees at least one valid.
   task automatic issue(input logic v0, input logic v1,
                        input logic [31:0] d0, input logic [31:0] s0, input logic l0, input logic a0,
                        input logic [31:0] d1, input logic [31:0] s1, input logic l1, input logic a1,
                        input logic [31:0] e0, input logic [31:0] e1, input int hold, input string tag);
      logic        g;
      logic [31:0] e;
      REQ0_VALID = v0; REQ0_D = d0; REQ0_S = s0; REQ0_LNR = l0; REQ0_SRA = a0;
      REQ1_VALID = v1; REQ1_D = d1; REQ1_S = s1; REQ1_LNR = l1; REQ1_SRA = a1;
      #1;
      g = (v0 && v1) ? m_ptr : v1;
      check({tag, ":rdy0"},  {31'b0, REQ0_READY}, {31'b0, v0 && !g});
      check({tag, ":rdy1"},  {31'b0, REQ1_READY}, {31'b0, v1 && g});
      check({tag, ":idle_v"}, {31'b0, RSP_VALID}, 32'd0);
      @(posedge CLK); #1;
      m_ptr = !g;
      e = g ? e1 : e0;
      check({tag, ":exec_v"},    {31'b0, RSP_VALID},  32'd0);
      check({tag, ":exec_rdy"},  {30'b0, REQ1_READY, REQ0_READY}, 32'd0);
      @(posedge CLK); #1;
      check({tag, ":valid"}, {31'b0, RSP_VALID}, 32'd1);
      check({tag, ":y"},     RSP_Y,              e);
      check({tag, ":id"},    {31'b0, RSP_ID},    {31'b0, g});
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK); #1;
         check({tag, ":hold_v"},   {31'b0, RSP_VALID}, 32'd1);
         check({tag, ":hold_y"},   RSP_Y,              e);
         check({tag, ":hold_id"},  {31'b0, RSP_ID},    {31'b0, g});
         check({tag, ":hold_rdy"}, {30'b0, REQ1_READY, REQ0_READY}, 32'd0);
      end
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      RSP_READY = 1'b0;
      check({tag, ":done_v"}, {31'b0, RSP_VALID}, 32'd0);
   endtask

   initial begin
      logic [31:0] d0, s0, d1, s1;
      logic        l0, a0, l1, a1, v0, v1;
      int          sel;
      RST = 1'b1; RSP_READY = 1'b0;
      REQ0_VALID = 1'b0; REQ0_D = '0; REQ0_S = '0; REQ0_LNR = 1'b0; REQ0_SRA = 1'b0;
      REQ1_VALID = 1'b0; REQ1_D = '0; REQ1_S = '0; REQ1_LNR = 1'b0; REQ1_SRA = 1'b0;
      reset_dut();

      issue(1, 0, 32'h8000_0001, 32'd1, 1, 0, '0, '0, 0, 0, 32'h0000_0002, '0, 0, "single");

      // A valid pulse that is gone before the edge must not be granted nor move the pointer.
      REQ0_VALID = 1'b1; #1; REQ0_VALID = 1'b0;
      @(posedge CLK); #1;
      check("glitch_v", {31'b0, RSP_VALID}, 32'd0);
      check("idle_rdy", {30'b0, REQ1_READY, REQ0_READY}, 32'd0);
      issue(1, 1, 32'h1, 32'd3, 1, 0, 32'h80, 32'd4, 0, 0, 32'h8, 32'h8, 0, "after_glitch");

      reset_dut();
      for (int i = 0; i < 4; i++)
         issue(1, 1, 32'h0000_0011, i, 1, 0, 32'h8000_0000, i, 0, 0,
               32'h0000_0011 << i, 32'h8000_0000 >> i, 0, "contend");

      issue(1, 0, 32'hFFFF_FFFF, 32'h20, 0, 0, '0, '0, 0, 0, 32'h0, '0, 0, "big_r");
      issue(0, 1, '0, '0, 0, 0, 32'hFFFF_FFFF, 32'h20, 1, 0, '0, 32'h0, 0, "big_l");
      issue(1, 0, 32'hFFFF_FFFF, 32'h20, 0, 1, '0, '0, 0, 0,
            SRA_ON ? 32'hFFFF_FFFF : 32'h0, '0, 0, "big_sra");
      issue(1, 0, 32'hF000_0000, 32'd4, 0, 1, '0, '0, 0, 0,
            SRA_ON ? 32'hFF00_0000 : 32'h0F00_0000, '0, 0, "sra4");
      issue(0, 1, '0, '0, 0, 0, 32'hF000_0000, 32'd1, 1, 1, '0, 32'hE000_0000, 0, "sra_left");
      issue(1, 1, 32'h1234_5678, 32'd8, 1, 0, 32'h8765_4321, 32'd12, 0, 0,
            32'h3456_7800, 32'h0008_7654, 5, "backpress");

      REQ0_VALID = 1'b1; REQ1_VALID = 1'b0; REQ0_D = 32'h5; REQ0_S = 32'd1; REQ0_LNR = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b1; #1;
      check("rexec_v",   {31'b0, RSP_VALID}, 32'd0);
      check("rexec_rdy", {30'b0, REQ1_READY, REQ0_READY}, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0; REQ0_VALID = 1'b0; m_ptr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         check("rexec_quiet", {31'b0, RSP_VALID}, 32'd0);
      end
      issue(1, 1, 32'h3, 32'd2, 1, 0, 32'h3, 32'd1, 1, 0, 32'hC, 32'h6, 0, "post_rst");

      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(1, 3);
         v0 = sel[0]; v1 = sel[1];
         d0 = $urandom; d1 = $urandom;
         l0 = $urandom_range(0, 1); l1 = $urandom_range(0, 1);
         a0 = $urandom_range(0, 1); a1 = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       begin s0 = $urandom_range(0, 31);  s1 = $urandom_range(0, 31); end
            1:       begin s0 = $urandom_range(32, 40); s1 = 32'd31; end
            2:       begin s0 = $urandom;               s1 = $urandom; end
            default: begin s0 = 32'd0;                  s1 = 32'h0000_0100; end
         endcase
         issue(v0, v1, d0, s0, l0, a0, d1, s1, l1, a1,
               ref_shift(d0, s0, l0, a0), ref_shift(d1, s1, l1, a1),
               $urandom_range(0, 2), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
